// File: rtl/hub75_scan_ctrl_if.sv
// Pixel-source and panel-side signal bundle for hub75_scan_ctrl.
// The master modport is the scan controller; the slave side is the pixel source plus panel.
`timescale 1ns/1ps
interface hub75_scan_ctrl_if #(
  parameter int NCOLS = 32
);
  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  logic          mode_req;
  logic [5:0]    pix_rgb;
  logic [CW-1:0] col;
  logic [2:0]    row;
  logic          mode_sel;
  logic          frame_start;
  logic [5:0]    rgb;
  logic          outclk;
  logic          lat;
  logic          oe;
  logic [2:0]    abc;

  modport master (
    input  mode_req, pix_rgb,
    output col, row, mode_sel, frame_start, rgb, outclk, lat, oe, abc
  );

  modport slave (
    output mode_req, pix_rgb,
    input  col, row, mode_sel, frame_start, rgb, outclk, lat, oe, abc
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// Row-scan sequencer for a 1/8-scan HUB75 panel: shifts NCOLS pixels per row pair,
// then blanks, latches, sets the row address and displays for ON_CYCLES clocks.
`timescale 1ns/1ps
module hub75_scan_ctrl #(
  parameter int NCOLS     = 32,
  parameter int CLKDIV    = 2,
  parameter int ON_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  hub75_scan_ctrl_if.master bus
);
  localparam int CW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int OW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
  localparam logic [3:0]    PH_LAST  = 4'(CLKDIV - 1);
  localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

  typedef enum logic [2:0] {
    SHIFT_LO = 3'd0,
    SHIFT_HI = 3'd1,
    BLANK    = 3'd2,
    LATCH    = 3'd3,
    ADDR     = 3'd4,
    DISPLAY  = 3'd5
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          run_r;
  logic [3:0]    phase_r, phase_nxt_s;
  logic [OW-1:0] on_r, on_nxt_s;
  logic [CW-1:0] col_r, col_nxt_s;
  logic [2:0]    row_r, row_nxt_s;
  logic          frame_nxt_s;

  logic          sync1_r, sync2_r;
  logic          mode_sel_r;
  logic          frame_start_r;
  logic [5:0]    rgb_r;
  logic          outclk_r;
  logic          lat_r;
  logic          oe_r;
  logic [2:0]    abc_r;

  assign bus.col         = col_r;
  assign bus.row         = row_r;
  assign bus.mode_sel    = mode_sel_r;
  assign bus.frame_start = frame_start_r;
  assign bus.rgb         = rgb_r;
  assign bus.outclk      = outclk_r;
  assign bus.lat         = lat_r;
  assign bus.oe          = oe_r;
  assign bus.abc         = abc_r;

  // Next-state, phase/on counters and col/row advance.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    on_nxt_s    = on_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    frame_nxt_s = 1'b0;
    case (state_r)
      SHIFT_LO: begin
        // The first edge after reset release only arms run_r, so that edge starts a full low phase.
        if (!run_r) begin
          phase_nxt_s = 4'd0;
        end else if (phase_r == PH_LAST) begin
          phase_nxt_s = 4'd0;
          state_nxt_s = SHIFT_HI;
        end else begin
          phase_nxt_s = phase_r + 4'd1;
        end
      end
      SHIFT_HI: begin
        if (phase_r == PH_LAST) begin
          phase_nxt_s = 4'd0;
          if (col_r == COL_LAST) begin
            col_nxt_s   = {CW{1'b0}};
            state_nxt_s = BLANK;
          end else begin
            col_nxt_s   = col_r + {{(CW-1){1'b0}}, 1'b1};
            state_nxt_s = SHIFT_LO;
          end
        end else begin
          phase_nxt_s = phase_r + 4'd1;
        end
      end
      BLANK: begin
        state_nxt_s = LATCH;
      end
      LATCH: begin
        state_nxt_s = ADDR;
      end
      ADDR: begin
        on_nxt_s    = {OW{1'b0}};
        state_nxt_s = DISPLAY;
      end
      DISPLAY: begin
        if (on_r == ON_LAST) begin
          on_nxt_s    = {OW{1'b0}};
          row_nxt_s   = row_r + 3'd1;
          state_nxt_s = SHIFT_LO;
          frame_nxt_s = (row_r == 3'd7);
        end else begin
          on_nxt_s = on_r + {{(OW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        phase_nxt_s = 4'd0;
        on_nxt_s    = {OW{1'b0}};
        state_nxt_s = SHIFT_LO;
      end
    endcase
  end

  // State, counters and registered panel outputs; outputs follow the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= SHIFT_LO;
      run_r         <= 1'b0;
      phase_r       <= 4'd0;
      on_r          <= {OW{1'b0}};
      col_r         <= {CW{1'b0}};
      row_r         <= 3'd0;
      sync1_r       <= 1'b0;
      sync2_r       <= 1'b0;
      mode_sel_r    <= 1'b0;
      frame_start_r <= 1'b0;
      rgb_r         <= 6'd0;
      outclk_r      <= 1'b0;
      lat_r         <= 1'b0;
      oe_r          <= 1'b1;
      abc_r         <= 3'd0;
    end else begin
      state_r       <= state_nxt_s;
      run_r         <= 1'b1;
      phase_r       <= phase_nxt_s;
      on_r          <= on_nxt_s;
      col_r         <= col_nxt_s;
      row_r         <= row_nxt_s;
      sync1_r       <= bus.mode_req;
      sync2_r       <= sync1_r;
      frame_start_r <= frame_nxt_s;
      outclk_r      <= (state_nxt_s == SHIFT_HI);
      lat_r         <= (state_nxt_s == LATCH);
      oe_r          <= (state_nxt_s != DISPLAY);
      if (frame_nxt_s) begin
        mode_sel_r <= sync2_r;
      end else begin
        mode_sel_r <= mode_sel_r;
      end
      if (state_nxt_s == ADDR) begin
        abc_r <= row_r;
      end else begin
        abc_r <= abc_r;
      end
      // pix_rgb reflects col one cycle into SHIFT_LO, so the final low-phase sample is the one clocked out.
      if (state_r == SHIFT_LO) begin
        rgb_r <= bus.pix_rgb;
      end else if (state_nxt_s == BLANK) begin
        rgb_r <= 6'd0;
      end else begin
        rgb_r <= rgb_r;
      end
    end
  end
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: default instance checked by per-cycle monitors,
// small instance (NCOLS=4, CLKDIV=3, ON_CYCLES=1) checked against a cycle-indexed vector table.
`timescale 1ns/1ps
module tb_hub75_scan_ctrl;
  logic clk;
  logic rst_a;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hub75_scan_ctrl_if #(.NCOLS(32)) bus_a ();
  hub75_scan_ctrl_if #(.NCOLS(4))  bus_b ();

  hub75_scan_ctrl dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.master)
  );

  hub75_scan_ctrl #(.NCOLS(4), .CLKDIV(3), .ON_CYCLES(1)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b.master)
  );

  assign bus_a.pix_rgb = 6'b100001;
  assign bus_b.pix_rgb = {bus_b.col, bus_b.col, bus_b.col} ^ 6'b101010;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic       mreq;
    logic       outclk;
    logic       lat;
    logic       oe;
    int         col;
    int         row;
    int         abc;
    logic [5:0] rgb;
    logic       fs;
    logic       msel;
  } vec_t;

  vec_t tbl[$];

  // per-cycle monitor state for dut_a
  logic       prev_outclk, prev_lat;
  logic [5:0] prev_rgb;
  logic [2:0] prev_abc;
  int rises, lats, oe_lows, bad_rgb, bad_oe, nchg;
  int chg[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int cyc, input logic mreq, input logic outclk, input logic lat,
                         input logic oe, input int col, input int row, input int abc,
                         input logic [5:0] rgb, input logic fs, input logic msel);
    vec_t v;
    v.cyc = cyc; v.mreq = mreq; v.outclk = outclk; v.lat = lat; v.oe = oe;
    v.col = col; v.row = row; v.abc = abc; v.rgb = rgb; v.fs = fs; v.msel = msel;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    prev_outclk = 1'b0; prev_lat = 1'b0; prev_rgb = 6'd0; prev_abc = 3'd0;
    rises = 0; lats = 0; oe_lows = 0; bad_rgb = 0;
  endtask

  task automatic sample_a();
    if (bus_a.outclk && !prev_outclk) begin
      rises++;
      if (prev_rgb != 6'b100001 || bus_a.rgb != 6'b100001) bad_rgb++;
    end
    if (bus_a.lat && !prev_lat) lats++;
    if (!bus_a.oe) oe_lows++;
    if ((bus_a.lat || bus_a.abc != prev_abc) && !bus_a.oe) bad_oe++;
    if (bus_a.abc != prev_abc) begin
      if (nchg < 8) chg[nchg] = int'(bus_a.abc);
      nchg++;
    end
    prev_outclk = bus_a.outclk;
    prev_lat    = bus_a.lat;
    prev_rgb    = bus_a.rgb;
    prev_abc    = bus_a.abc;
  endtask

  initial begin
    int ti;
    int fs_count;
    int fs_cyc;
    int bad_mode;
    int bad_lat;

    // cyc mreq oclk lat oe col row abc rgb fs msel
    add_vec(  0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 6'b101010, 1'b0, 1'b0);
    add_vec(  2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 6'b101010, 1'b0, 1'b0);
    add_vec(  3, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 6'b101010, 1'b0, 1'b0);
    add_vec(  5, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 6'b101010, 1'b0, 1'b0);
    add_vec(  6, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 6'b101010, 1'b0, 1'b0);
    add_vec(  7, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 6'b111111, 1'b0, 1'b0);
    add_vec(  9, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 6'b111111, 1'b0, 1'b0);
    add_vec( 13, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 15, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 21, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 0, 6'b010101, 1'b0, 1'b0);
    add_vec( 24, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 25, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 26, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 27, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 28, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 6'b000000, 1'b0, 1'b0);
    add_vec( 29, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 6'b101010, 1'b0, 1'b0);
    add_vec( 54, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 6'b000000, 1'b0, 1'b0);
    add_vec( 55, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1, 6'b000000, 1'b0, 1'b0);
    add_vec(100, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 2, 6'b000000, 1'b0, 1'b0);
    add_vec(223, 1'b1, 1'b0, 1'b0, 1'b0, 0, 7, 7, 6'b000000, 1'b0, 1'b0);
    add_vec(224, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 7, 6'b000000, 1'b1, 1'b1);
    add_vec(225, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 7, 6'b101010, 1'b0, 1'b1);
    add_vec(250, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 6'b000000, 1'b0, 1'b1);

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.mode_req = 1'b0;
    bus_b.mode_req = 1'b0;
    repeat (3) step();

    chk("rst_oe",          int'(bus_a.oe), 1);
    chk("rst_lat",         int'(bus_a.lat), 0);
    chk("rst_outclk",      int'(bus_a.outclk), 0);
    chk("rst_col",         int'(bus_a.col), 0);
    chk("rst_row",         int'(bus_a.row), 0);
    chk("rst_abc",         int'(bus_a.abc), 0);
    chk("rst_rgb",         int'(bus_a.rgb), 0);
    chk("rst_mode_sel",    int'(bus_a.mode_sel), 0);
    chk("rst_frame_start", int'(bus_a.frame_start), 0);
    chk("rst_b_oe",        int'(bus_b.oe), 1);

    clear_stats();
    bad_oe = 0; nchg = 0; fs_count = 0; fs_cyc = -1; bad_mode = 0; ti = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int c = 0; c < 4458; c++) begin
      step();
      sample_a();
      if (bus_a.frame_start) begin
        fs_count++;
        if (fs_count == 1) fs_cyc = c;
      end
      if (c < 3096 && bus_a.mode_sel) bad_mode++;
      if (c == 100) bus_a.mode_req = 1'b1;
      if (c == 386) begin
        chk("row0_outclk_rises", rises, 32);
        chk("row0_lat_pulses",   lats, 1);
        chk("row0_oe_low",       oe_lows, 256);
        chk("row0_rgb_stable",   bad_rgb, 0);
        chk("row0_abc",          int'(bus_a.abc), 0);
        chk("row_before_387",    int'(bus_a.row), 0);
      end
      if (c == 387) chk("row_at_387", int'(bus_a.row), 1);
      if (c == 3095) chk("mode_sel_3095", int'(bus_a.mode_sel), 0);
      if (c == 3096) chk("mode_sel_3096", int'(bus_a.mode_sel), 1);
      if (c == 3300) begin
        chk("frame_start_count", fs_count, 1);
        chk("frame_start_cycle", fs_cyc, 3096);
        chk("mode_sel_mid_frame", bad_mode, 0);
        chk("abc_changes", nchg, 8);
        for (int k = 0; k < 8; k++)
          chk($sformatf("abc_seq[%0d]", k), chg[k], (k + 1) % 8);
        chk("frame_rgb_stable", bad_rgb, 0);
      end
      if (c == 4457) begin
        chk("pre_rst_oe",  int'(bus_a.oe), 0);
        chk("pre_rst_row", int'(bus_a.row), 3);
        chk("pre_rst_abc", int'(bus_a.abc), 3);
      end
      if (ti < tbl.size() && tbl[ti].cyc == c) begin
        chk($sformatf("b_outclk@%0d", c), int'(bus_b.outclk),      int'(tbl[ti].outclk));
        chk($sformatf("b_lat@%0d", c),    int'(bus_b.lat),         int'(tbl[ti].lat));
        chk($sformatf("b_oe@%0d", c),     int'(bus_b.oe),          int'(tbl[ti].oe));
        chk($sformatf("b_col@%0d", c),    int'(bus_b.col),         tbl[ti].col);
        chk($sformatf("b_row@%0d", c),    int'(bus_b.row),         tbl[ti].row);
        chk($sformatf("b_abc@%0d", c),    int'(bus_b.abc),         tbl[ti].abc);
        chk($sformatf("b_rgb@%0d", c),    int'(bus_b.rgb),         int'(tbl[ti].rgb));
        chk($sformatf("b_fs@%0d", c),     int'(bus_b.frame_start), int'(tbl[ti].fs));
        chk($sformatf("b_msel@%0d", c),   int'(bus_b.mode_sel),    int'(tbl[ti].msel));
        bus_b.mode_req = tbl[ti].mreq;
        ti++;
      end
    end
    chk("table_consumed", ti, tbl.size());

    // Reset in mid-DISPLAY of row 3, away from any clock edge.
    #1;
    rst_a = 1'b1;
    #1;
    chk("midrst_oe",     int'(bus_a.oe), 1);
    chk("midrst_lat",    int'(bus_a.lat), 0);
    chk("midrst_abc",    int'(bus_a.abc), 0);
    chk("midrst_row",    int'(bus_a.row), 0);
    chk("midrst_col",    int'(bus_a.col), 0);
    chk("midrst_outclk", int'(bus_a.outclk), 0);
    bad_lat = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus_a.lat || !bus_a.oe) bad_lat++;
    end
    chk("held_rst_blank", bad_lat, 0);

    clear_stats();
    rst_a = 1'b0;
    for (int c = 0; c < 388; c++) begin
      step();
      sample_a();
      if (c == 0) chk("rerun_first_outclk", int'(bus_a.outclk), 0);
      if (c == 2) chk("rerun_first_rise", int'(bus_a.outclk), 1);
      if (c == 386) begin
        chk("rerun_outclk_rises", rises, 32);
        chk("rerun_lat_pulses",   lats, 1);
        chk("rerun_oe_low",       oe_lows, 256);
        chk("rerun_rgb_stable",   bad_rgb, 0);
        chk("rerun_row_386",      int'(bus_a.row), 0);
        chk("rerun_frame_start",  int'(bus_a.frame_start), 0);
      end
      if (c == 387) chk("rerun_row_387", int'(bus_a.row), 1);
    end
    chk("oe_high_on_lat_abc", bad_oe, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
